// File: rtl/rvc_cb_exec_pipe.sv
// Two-stage stallable execute pipe for compressed CB-format instructions
// (c.beqz, c.bnez, c.srli, c.srai, c.andi) with flush and illegal reporting.
module rvc_cb_exec_pipe #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iFLUSH,
    input  logic            iVALID,
    output logic            oREADY,
    input  logic [15:0]     iIR,
    input  logic [PC_W-1:0] iPC,
    input  logic [XLEN-1:0] iRS,
    input  logic            iREADY,
    output logic            oVALID,
    output logic [4:0]      oRD,
    output logic            oWE,
    output logic [XLEN-1:0] oRESULT,
    output logic            oTAKEN,
    output logic [PC_W-1:0] oNEXT_PC,
    output logic            oILLEGAL
);

    localparam bit IS_RV32 = (XLEN == 32);

    logic            aValid;
    logic [15:0]     aIr;
    logic [PC_W-1:0] aPc;
    logic [XLEN-1:0] aRs;
    logic            bValid;
    logic            bLoad;
    logic            accept;

    logic [5:0]             shamt;
    logic [8:0]             brOff;
    logic [XLEN-1:0]        andImm;
    logic signed [XLEN-1:0] sraVal;
    logic [PC_W-1:0]        pcPlus2;
    logic [PC_W-1:0]        pcBranch;
    logic [4:0]             dRd;
    logic                   dWe;
    logic [XLEN-1:0]        dResult;
    logic                   dTaken;
    logic [PC_W-1:0]        dNextPc;
    logic                   dIllegal;

    // Handshake: B drains or refills, A refills whenever B takes its entry.
    assign bLoad  = aValid && (!bValid || iREADY);
    assign oREADY = !aValid || bLoad;
    assign accept = iVALID && oREADY && !iFLUSH;
    assign oVALID = bValid;

    // Decode and execute the instruction held in stage A.
    always_comb begin
        shamt    = {aIr[12], aIr[6:2]};
        brOff    = {aIr[12], aIr[6:5], aIr[2], aIr[11:10], aIr[4:3], 1'b0};
        andImm   = {{(XLEN-6){aIr[12]}}, aIr[12], aIr[6:2]};
        sraVal   = $signed(aRs) >>> shamt;
        pcPlus2  = aPc + PC_W'(2);
        pcBranch = aPc + {{(PC_W-9){brOff[8]}}, brOff};
        dRd      = {2'b01, aIr[9:7]};
        dWe      = 1'b0;
        dResult  = '0;
        dTaken   = 1'b0;
        dNextPc  = pcPlus2;
        dIllegal = 1'b1;
        if (aIr[1:0] == 2'b01) begin
            case (aIr[15:13])
                3'b110, 3'b111: begin
                    dIllegal = 1'b0;
                    dTaken   = aIr[13] ? (aRs != '0) : (aRs == '0);
                    if (dTaken) begin
                        dNextPc = pcBranch;
                    end
                end
                3'b100: begin
                    case (aIr[11:10])
                        2'b10: begin
                            dIllegal = 1'b0;
                            dWe      = 1'b1;
                            dResult  = aRs & andImm;
                        end
                        2'b00, 2'b01: begin
                            if (!(IS_RV32 && aIr[12])) begin
                                dIllegal = 1'b0;
                                if (shamt == 6'd0) begin
                                    dResult = aRs;
                                end else begin
                                    dWe     = 1'b1;
                                    dResult = aIr[10] ? XLEN'(sraVal) : (aRs >> shamt);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Pipeline registers; flush beats accept, reset beats everything.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            aValid   <= 1'b0;
            aIr      <= '0;
            aPc      <= '0;
            aRs      <= '0;
            bValid   <= 1'b0;
            oRD      <= '0;
            oWE      <= 1'b0;
            oRESULT  <= '0;
            oTAKEN   <= 1'b0;
            oNEXT_PC <= '0;
            oILLEGAL <= 1'b0;
        end else begin
            if (iFLUSH) begin
                aValid <= 1'b0;
            end else if (accept) begin
                aValid <= 1'b1;
                aIr    <= iIR;
                aPc    <= iPC;
                aRs    <= iRS;
            end else if (bLoad) begin
                aValid <= 1'b0;
            end

            if (iFLUSH) begin
                bValid <= 1'b0;
            end else if (bLoad) begin
                bValid   <= 1'b1;
                oRD      <= dRd;
                oWE      <= dWe;
                oRESULT  <= dResult;
                oTAKEN   <= dTaken;
                oNEXT_PC <= dNextPc;
                oILLEGAL <= dIllegal;
            end else if (iREADY) begin
                bValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rvc_cb_exec_pipe.sv
// Scoreboard bench for rvc_cb_exec_pipe: directed CB cases, backpressure,
// flush, async reset and a randomized stream against a behavioural model.
module tb_rvc_cb_exec_pipe;

    logic        iCLK, iRST, iFLUSH, iVALID, iREADY;
    logic        oREADY, oVALID, oWE, oTAKEN, oILLEGAL;
    logic [15:0] iIR;
    logic [31:0] iPC, iRS, oRESULT, oNEXT_PC;
    logic [4:0]  oRD;

    rvc_cb_exec_pipe #(.XLEN(32), .PC_W(32)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFLUSH(iFLUSH), .iVALID(iVALID), .oREADY(oREADY),
        .iIR(iIR), .iPC(iPC), .iRS(iRS), .iREADY(iREADY), .oVALID(oVALID),
        .oRD(oRD), .oWE(oWE), .oRESULT(oRESULT), .oTAKEN(oTAKEN),
        .oNEXT_PC(oNEXT_PC), .oILLEGAL(oILLEGAL)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] result;
        logic        taken;
        logic [31:0] nextPc;
        logic        ill;
        longint      tAcc;
        bit          chkLat;
    } expT;

    expT         q[$];
    int          checks = 0;
    int          errors = 0;
    bit          latMode = 0;
    bit          rdyRand = 0;
    bit          seenHead = 0;
    bit          holdPrev = 0;
    logic [71:0] prevBundle;

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got running required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic expT mk(input logic [4:0] rd, input logic we, input logic [31:0] res,
                               input logic tk, input logic [31:0] npc, input logic ill);
        expT e;
        e.rd = rd; e.we = we; e.result = res; e.taken = tk; e.nextPc = npc; e.ill = ill;
        e.tAcc = 0; e.chkLat = 0;
        return e;
    endfunction

    // Reference: instruction semantics written from the ISA rules with integer arithmetic.
    function automatic expT model(input logic [15:0] ir, input logic [31:0] pc, input logic [31:0] rs);
        expT e;
        int  off, six, imm;
        e = mk(5'(8 + int'(ir[9:7])), 1'b0, 32'd0, 1'b0, pc + 32'd2, 1'b0);
        six = int'({ir[12], ir[6:2]});
        if (ir[1:0] != 2'b01) begin
            e.ill = 1'b1;
        end else if (ir[15:13] == 3'b110 || ir[15:13] == 3'b111) begin
            off = (ir[12] ? -256 : 0) + int'(ir[6:5]) * 64 + int'(ir[2]) * 32
                  + int'(ir[11:10]) * 8 + int'(ir[4:3]) * 2;
            e.taken  = (ir[15:13] == 3'b110) ? (rs == 0) : (rs != 0);
            e.nextPc = e.taken ? pc + 32'(off) : pc + 32'd2;
        end else if (ir[15:13] == 3'b100) begin
            if (ir[11:10] == 2'd3) begin
                e.ill = 1'b1;
            end else if (ir[11:10] == 2'd2) begin
                imm = ir[12] ? six - 64 : six;
                e.result = rs & 32'(imm);
                e.we = 1'b1;
            end else if (ir[12]) begin
                e.ill = 1'b1;
            end else if (six == 0) begin
                e.result = rs;
            end else begin
                e.we = 1'b1;
                if (ir[10] && rs[31]) e.result = ~((~rs) >> six);
                else                  e.result = rs >> six;
            end
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [15:0] randIr();
        logic [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(0, 4) != 0) begin
            r[1:0] = 2'b01;
            case ($urandom_range(0, 2))
                0:       r[15:13] = 3'b100;
                1:       r[15:13] = 3'b110;
                default: r[15:13] = 3'b111;
            endcase
        end
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] ir, input logic [31:0] pc, input logic [31:0] rs, input expT e);
        int n = 0;
        bit acc = 0;
        iVALID = 1'b1; iIR = ir; iPC = pc; iRS = rs;
        while (!acc && n < 200) begin
            @(negedge iCLK);
            acc = oREADY;
            @(posedge iCLK);
            n++;
        end
        if (acc) begin
            e.tAcc = $time;
            e.chkLat = latMode;
            q.push_back(e);
        end else begin
            check("send_timeout", 80'(acc), 80'd1);
        end
        #1 iVALID = 1'b0;
    endtask

    task automatic sendRand();
        logic [15:0] ir;
        logic [31:0] pc, rs;
        ir = randIr();
        pc = $urandom & 32'hFFFF_FFFE;
        rs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        send(ir, pc, rs, model(ir, pc, rs));
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_oVALID"}, 80'(oVALID), 80'd0);
        check({tag, "_fields"}, 80'({oRD, oWE, oRESULT, oTAKEN, oNEXT_PC, oILLEGAL}), 80'd0);
    endtask

    initial begin
        forever begin
            @(posedge iCLK);
            #1;
            if (rdyRand) iREADY = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: stability under backpressure, latency, and in-order scoreboard pops.
    initial begin
        expT e;
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                holdPrev = 0;
            end else begin
                if (holdPrev) begin
                    check("hold_valid", 80'(oVALID), 80'd1);
                    check("hold_fields", 80'({oRD, oWE, oRESULT, oTAKEN, oNEXT_PC, oILLEGAL}), 80'(prevBundle));
                end
                if (oVALID && q.size() > 0 && !seenHead) begin
                    seenHead = 1;
                    if (q[0].chkLat) check("latency", 80'($time - q[0].tAcc), 80'd15);
                end
                if (oVALID && iREADY) begin
                    if (q.size() == 0) begin
                        check("unexpected_output", 80'(oVALID), 80'd0);
                    end else begin
                        e = q.pop_front();
                        seenHead = 0;
                        check("rd", 80'(oRD), 80'(e.rd));
                        check("we", 80'(oWE), 80'(e.we));
                        check("taken", 80'(oTAKEN), 80'(e.taken));
                        check("illegal", 80'(oILLEGAL), 80'(e.ill));
                        if (!e.ill) begin
                            check("result", 80'(oRESULT), 80'(e.result));
                            check("next_pc", 80'(oNEXT_PC), 80'(e.nextPc));
                        end
                    end
                end
                holdPrev = oVALID && !iREADY && !iFLUSH;
                prevBundle = {oRD, oWE, oRESULT, oTAKEN, oNEXT_PC, oILLEGAL};
            end
        end
    end

    initial begin
        int n;
        iRST = 1'b0; iFLUSH = 1'b0; iVALID = 1'b0; iREADY = 1'b1;
        iIR = '0; iPC = '0; iRS = '0;
        #1 iRST = 1'b1;
        #1 checkResetOutputs("reset_async");
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b0;
        @(negedge iCLK);
        check("reset_ready", 80'(oREADY), 80'd1);
        checkResetOutputs("reset_idle");
        @(posedge iCLK); #1;

        // Directed CB cases, downstream always ready.
        latMode = 1;
        send(16'hC401, 32'h100, 32'd0, mk(5'd8, 0, 32'd0, 1, 32'h108, 0));
        send(16'hC401, 32'h100, 32'd5, mk(5'd8, 0, 32'd0, 0, 32'h102, 0));
        send(16'hFC7D, 32'h0, 32'd1, mk(5'd8, 0, 32'd0, 1, 32'hFFFF_FFFE, 0));
        send(16'h8491, 32'h200, 32'h8000_0000, mk(5'd9, 1, 32'hF800_0000, 0, 32'h202, 0));
        send(16'h9841, 32'h204, 32'h1234_5678, mk(5'd8, 1, 32'h1234_5670, 0, 32'h206, 0));
        send(16'h9005, 32'h300, 32'h1234, mk(5'd8, 0, 32'd0, 0, 32'h302, 1));
        send(16'h8001, 32'h302, 32'hABCD, mk(5'd8, 0, 32'hABCD, 0, 32'h304, 0));
        latMode = 0;
        repeat (4) @(posedge iCLK);
        #1;

        // Backpressure: four back-to-back instructions, iREADY low for three edges.
        iREADY = 1'b0;
        sendRand();
        sendRand();
        @(negedge iCLK);
        check("bp_ready_drop", 80'(oREADY), 80'd0);
        check("bp_valid", 80'(oVALID), 80'd1);
        fork
            begin @(posedge iCLK); #1; sendRand(); sendRand(); end
            begin @(posedge iCLK); #1 iREADY = 1'b1; end
        join
        repeat (4) @(posedge iCLK);
        #1;

        // Flush with both stages full and a concurrent valid input.
        iREADY = 1'b0;
        sendRand();
        sendRand();
        iFLUSH = 1'b1; iVALID = 1'b1; iIR = 16'hC401; iPC = 32'h400; iRS = 32'd0;
        @(posedge iCLK);
        #1 iFLUSH = 1'b0; iVALID = 1'b0;
        q.delete(); seenHead = 0;
        @(negedge iCLK);
        check("flush_full_valid", 80'(oVALID), 80'd0);
        check("flush_full_ready", 80'(oREADY), 80'd1);
        @(posedge iCLK); #1 iREADY = 1'b1;

        // Flush while only A is occupied and oREADY is high: input must be dropped.
        sendRand();
        iFLUSH = 1'b1; iVALID = 1'b1; iIR = 16'h8491; iPC = 32'h500; iRS = 32'h8000_0000;
        @(negedge iCLK);
        check("flush_a_ready", 80'(oREADY), 80'd1);
        @(posedge iCLK);
        #1 iFLUSH = 1'b0; iVALID = 1'b0;
        q.delete(); seenHead = 0;
        @(negedge iCLK);
        check("flush_a_valid", 80'(oVALID), 80'd0);
        repeat (5) @(posedge iCLK);
        #1;

        // Asynchronous reset mid-stream with both stages full.
        iREADY = 1'b0;
        send(16'h9841, 32'h600, 32'hFFFF_FFFF, model(16'h9841, 32'h600, 32'hFFFF_FFFF));
        send(16'hC401, 32'h700, 32'd0, model(16'hC401, 32'h700, 32'd0));
        @(posedge iCLK);
        #2 iRST = 1'b1;
        #1 checkResetOutputs("reset_mid");
        check("reset_mid_ready", 80'(oREADY), 80'd1);
        q.delete(); seenHead = 0;
        @(posedge iCLK);
        #1 iRST = 1'b0; iREADY = 1'b1;
        @(negedge iCLK);
        check("reset_mid_ready_after", 80'(oREADY), 80'd1);
        check("reset_mid_valid_after", 80'(oVALID), 80'd0);
        @(posedge iCLK); #1;

        // Randomized stream with random gaps and random downstream stalls.
        rdyRand = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge iCLK); #1;
            end
            sendRand();
        end
        rdyRand = 0;
        iREADY = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 500) begin
            @(posedge iCLK);
            n++;
        end
        check("drain_pending", 80'(q.size()), 80'd0);
        repeat (3) @(posedge iCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
